id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- Decode→execute pipeline register for the MIPS-24 core. It sits directly downstream of regFile and captures dataOutA/dataOutB with the decoded instruction fields.
- Performs write-back bypass at capture and EX/MEM + MEM/WB operand forwarding at its output.
- Detects load-use hazards and issues stall/bubble.
- Supports flush and downstream hold.

Parameters:
- DATA_W, 24, datapath width
- REG_AW, 3, register index width (8 registers)
- CTRL_W, 8, opaque execute-control bundle width, passed through unchanged

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- id_valid  in  1  decode slot holds a real instruction
- id_rs, id_rt, id_rd  in  REG_AW each  decoded register indices
- id_uses_rs, id_uses_rt  in  1 each  instruction reads rs/rt
- id_a, id_b  in  DATA_W each  regFile dataOutA/dataOutB
- id_imm  in  DATA_W  sign-extended immediate
- id_ctrl  in  CTRL_W  execute control bundle
- id_we  in  1  instruction writes rd
- id_is_load  in  1  instruction is a load
- flush  in  1  kill decode slot (branch taken)
- ex_hold  in  1  execute cannot accept (multicycle op)
- mem_we, mem_rd, mem_data  in  1/REG_AW/DATA_W  EX/MEM result bus
- wb_we, wb_rd, wb_data  in  1/REG_AW/DATA_W  MEM/WB bus (same bus drives the regFile write port)
- stall  out  1  freeze PC and IF/ID
- ex_valid, ex_we, ex_is_load  out  1 each
- ex_rs, ex_rt, ex_rd  out  REG_AW
- ex_ctrl  out  CTRL_W
- ex_imm  out  DATA_W
- ex_a, ex_b  out  DATA_W  forwarded operands

Behaviour:
- Reset: rst_n low clears all pipeline registers asynchronously. All outputs are 0, including stall. This holds mid-operation.
- Register index 0 is not special. Forwarding and hazard compares match any index.
- Capture bypass: when loading from decode, if wb_we && wb_rd==id_rs, ex_a_q <= wb_data, else id_a. The rt/id_b path is identical. This covers the regFile write landing on the same edge.
- Output forwarding (combinational, per operand, rs shown):
  - ex_uses_rs && mem_we && mem_rd==ex_rs → mem_data
  - else ex_uses_rs && wb_we && wb_rd==ex_rs → wb_data
  - else ex_a_q
  - EX/MEM has priority over MEM/WB.
- Load-use: luh = ex_valid && ex_is_load && ex_we && id_valid && ((id_uses_rs && id_rs==ex_rd) || (id_uses_rt && id_rt==ex_rd)).
- stall = luh || ex_hold, combinational. It is forced to 0 while flush is asserted.
- Per-edge priority:
  1. flush: ex_valid<=0, other fields don't-care, stall 0. Flush also kills the EX slot when ex_hold=0. When ex_hold=1 the EX slot is kept and only decode is killed.
  2. ex_hold: all EX registers keep their values. ex_a_q/ex_b_q are refreshed with the current forwarded values, so a held operand survives producers retiring.
  3. luh: bubble, ex_valid<=0, ex_we<=0, ex_is_load<=0.
  4. Normal: load all decode fields. ex_valid<=id_valid.
- Latency: one cycle from decode to EX outputs. A dependent instruction after a load waits exactly one bubble.
- Invalid slots never forward, never hazard, and never write.

Decomposition:
- Package mips24_pkg: DATA_W, REG_AW, NUM_REGS=8, CTRL_W, and a struct/bundle for the ID→EX fields.
- Sub-module fwd_mux: one operand's 3-way priority forward. Instantiated twice, for a and b.

Test Plan:
- Reset: rst_n=0 mid-stream with ex_valid=1 → all outputs 0 immediately. On release, the first id_valid instruction appears on ex_* one edge later.
- EX/MEM forward: EX holds rs=3, a_q=5; mem_we=1, mem_rd=3, mem_data=0x00ABCD; wb also targets 3 with 0x111111 → ex_a=0x00ABCD.
- Capture bypass: id_rs=7, id_a=100, wb_we=1, wb_rd=7, wb_data=200 → after edge, ex_a=200 with no other forward.
- Load-use: EX is lw to r2 (valid, we, is_load); ID add uses rt=2 → stall=1 for one cycle, ex_valid=0 next cycle. The next cycle stall=0, and ex_b takes mem_data from the load.
- Hold refresh: ex_hold=1 for 3 cycles, ex_rs=4, wb_we=1 to r4 with 0x000042 in cycle 1 only → ex_a=0x000042 in cycles 2–3 and after release.
- Flush with luh active: stall=0, ex_valid=0 next edge.

Source files
------------

// File: rtl/mips24_pkg.sv
// Shared widths and the ID->EX pipeline bundle for the MIPS-24 core.
package mips24_pkg;

  localparam int DATA_W   = 24;
  localparam int REG_AW   = 3;
  localparam int NUM_REGS = 8;
  localparam int CTRL_W   = 8;

  typedef struct packed {
    logic              valid;
    logic              we;
    logic              isLoad;
    logic              usesRs;
    logic              usesRt;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } idExBundle_t;

endpackage

// File: rtl/fwd_mux.sv
// One operand's forwarding select: EX/MEM beats MEM/WB beats the registered value.
module fwd_mux
  import mips24_pkg::*;
(
  input  logic              uses,
  input  logic [REG_AW-1:0] srcReg,
  input  logic [DATA_W-1:0] regQ,
  input  logic              memWe,
  input  logic [REG_AW-1:0] memRd,
  input  logic [DATA_W-1:0] memData,
  input  logic              wbWe,
  input  logic [REG_AW-1:0] wbRd,
  input  logic [DATA_W-1:0] wbData,
  output logic [DATA_W-1:0] operand
);

  always_comb begin
    operand = regQ;
    if (uses && memWe && (memRd == srcReg)) begin
      operand = memData;
    end else if (uses && wbWe && (wbRd == srcReg)) begin
      operand = wbData;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// Decode->execute pipeline register with capture bypass, output forwarding,
// load-use stall generation, flush and downstream hold.
module id_ex_stage
  import mips24_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [DATA_W-1:0] id_a,
  input  logic [DATA_W-1:0] id_b,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              id_we,
  input  logic              id_is_load,
  input  logic              flush,
  input  logic              ex_hold,
  input  logic              mem_we,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              stall,
  output logic              ex_valid,
  output logic              ex_we,
  output logic              ex_is_load,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_rd,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b
);

  idExBundle_t       exQ;
  idExBundle_t       exNext;
  logic [DATA_W-1:0] fwdA;
  logic [DATA_W-1:0] fwdB;
  logic              luh;

  // An empty EX slot must never pull a forwarded value.
  fwd_mux uFwdA (
    .uses    (exQ.valid && exQ.usesRs),
    .srcReg  (exQ.rs),
    .regQ    (exQ.a),
    .memWe   (mem_we),
    .memRd   (mem_rd),
    .memData (mem_data),
    .wbWe    (wb_we),
    .wbRd    (wb_rd),
    .wbData  (wb_data),
    .operand (fwdA)
  );

  fwd_mux uFwdB (
    .uses    (exQ.valid && exQ.usesRt),
    .srcReg  (exQ.rt),
    .regQ    (exQ.b),
    .memWe   (mem_we),
    .memRd   (mem_rd),
    .memData (mem_data),
    .wbWe    (wb_we),
    .wbRd    (wb_rd),
    .wbData  (wb_data),
    .operand (fwdB)
  );

  always_comb begin
    luh = exQ.valid && exQ.isLoad && exQ.we && id_valid &&
          ((id_uses_rs && (id_rs == exQ.rd)) || (id_uses_rt && (id_rt == exQ.rd)));
    stall = rst_n && !flush && (luh || ex_hold);
  end

  always_comb begin
    exNext = exQ;
    // Hold outranks the EX-slot kill: a flush during hold only discards decode.
    if (ex_hold) begin
      exNext.a = fwdA;
      exNext.b = fwdB;
    end else if (flush || luh) begin
      exNext.valid  = 1'b0;
      exNext.we     = 1'b0;
      exNext.isLoad = 1'b0;
    end else begin
      exNext.valid  = id_valid;
      exNext.we     = id_valid && id_we;
      exNext.isLoad = id_valid && id_is_load;
      exNext.usesRs = id_valid && id_uses_rs;
      exNext.usesRt = id_valid && id_uses_rt;
      exNext.rs     = id_rs;
      exNext.rt     = id_rt;
      exNext.rd     = id_rd;
      exNext.ctrl   = id_ctrl;
      exNext.imm    = id_imm;
      // The regFile write landing on this same edge is not yet in id_a/id_b.
      exNext.a      = (wb_we && (wb_rd == id_rs)) ? wb_data : id_a;
      exNext.b      = (wb_we && (wb_rd == id_rt)) ? wb_data : id_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exQ <= '0;
    end else begin
      exQ <= exNext;
    end
  end

  assign ex_valid   = exQ.valid;
  assign ex_we      = exQ.we;
  assign ex_is_load = exQ.isLoad;
  assign ex_rs      = exQ.rs;
  assign ex_rt      = exQ.rt;
  assign ex_rd      = exQ.rd;
  assign ex_ctrl    = exQ.ctrl;
  assign ex_imm     = exQ.imm;
  assign ex_a       = fwdA;
  assign ex_b       = fwdB;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed scoreboard bench for id_ex_stage.
module tb_id_ex_stage;
  import mips24_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              id_valid, id_uses_rs, id_uses_rt, id_we, id_is_load;
  logic [REG_AW-1:0] id_rs, id_rt, id_rd;
  logic [DATA_W-1:0] id_a, id_b, id_imm;
  logic [CTRL_W-1:0] id_ctrl;
  logic              flush, ex_hold;
  logic              mem_we, wb_we;
  logic [REG_AW-1:0] mem_rd, wb_rd;
  logic [DATA_W-1:0] mem_data, wb_data;
  logic              stall, ex_valid, ex_we, ex_is_load;
  logic [REG_AW-1:0] ex_rs, ex_rt, ex_rd;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [DATA_W-1:0] ex_imm, ex_a, ex_b;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] expQ[$];
  string       tagQ[$];

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_a(id_a), .id_b(id_b), .id_imm(id_imm), .id_ctrl(id_ctrl),
    .id_we(id_we), .id_is_load(id_is_load),
    .flush(flush), .ex_hold(ex_hold),
    .mem_we(mem_we), .mem_rd(mem_rd), .mem_data(mem_data),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .stall(stall), .ex_valid(ex_valid), .ex_we(ex_we), .ex_is_load(ex_is_load),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_ctrl(ex_ctrl), .ex_imm(ex_imm), .ex_a(ex_a), .ex_b(ex_b)
  );

  task automatic push(input string tag, input logic [31:0] val);
    tagQ.push_back(tag);
    expQ.push_back(val);
  endtask

  task automatic check(input logic [31:0] obs);
    logic [31:0] exp;
    string       tag;
    if (expQ.size() == 0) begin
      miscompares++;
      $display("FAIL scoreboard_underflow observed=%h expected=none", obs);
    end else begin
      exp = expQ.pop_front();
      tag = tagQ.pop_front();
      vectors++;
      assert (obs === exp) else begin
        miscompares++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
      $display("vector %0d %s observed=%h expected=%h", vectors, tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_uses_rs = 0; id_uses_rt = 0; id_we = 0; id_is_load = 0;
    id_rs = 0; id_rt = 0; id_rd = 0; id_a = 0; id_b = 0; id_imm = 0; id_ctrl = 0;
    flush = 0; ex_hold = 0;
    mem_we = 0; mem_rd = 0; mem_data = 0;
    wb_we = 0; wb_rd = 0; wb_data = 0;
  endtask

  task automatic issue(input logic [REG_AW-1:0] rs, input logic [REG_AW-1:0] rt,
                       input logic [REG_AW-1:0] rd, input logic [DATA_W-1:0] a,
                       input logic [DATA_W-1:0] b, input logic ld);
    id_valid = 1; id_uses_rs = 1; id_uses_rt = 1; id_we = 1; id_is_load = ld;
    id_rs = rs; id_rt = rt; id_rd = rd; id_a = a; id_b = b;
  endtask

  initial begin
    idle();
    rst_n = 0;
    step(); step();
    rst_n = 1;
    #1;
    push("reset_ex_valid", 0); check(32'(ex_valid));
    push("reset_stall", 0);    check(32'(stall));
    push("reset_ex_a", 0);     check(32'(ex_a));

    // Capture bypass: wb write to rs lands on the capture edge.
    issue(3'd7, 3'd1, 3'd5, 24'd100, 24'd55, 1'b0);
    id_imm = 24'h000123; id_ctrl = 8'h5A;
    wb_we = 1; wb_rd = 3'd7; wb_data = 24'd200;
    push("bypass_ex_a", 200); push("bypass_ex_b", 55); push("bypass_ex_rd", 5);
    push("bypass_ctrl", 8'h5A); push("bypass_imm", 24'h000123); push("bypass_valid", 1);
    step();
    idle();
    #1;
    check(32'(ex_a)); check(32'(ex_b)); check(32'(ex_rd));
    check(32'(ex_ctrl)); check(32'(ex_imm)); check(32'(ex_valid));

    // EX/MEM outranks MEM/WB; then WB alone; then the register value.
    issue(3'd3, 3'd0, 3'd6, 24'd5, 24'd0, 1'b0);
    step();
    idle();
    mem_we = 1; mem_rd = 3'd3; mem_data = 24'h00ABCD;
    wb_we = 1; wb_rd = 3'd3; wb_data = 24'h111111;
    push("fwd_mem_priority", 24'h00ABCD);
    #1; check(32'(ex_a));
    mem_we = 0;
    push("fwd_wb", 24'h111111);
    #1; check(32'(ex_a));
    wb_we = 0;
    push("fwd_none", 5);
    #1; check(32'(ex_a));

    // Load-use: lw r2 in EX, dependent add in ID.
    issue(3'd0, 3'd0, 3'd2, 24'd0, 24'd0, 1'b1);
    step();
    issue(3'd1, 3'd2, 3'd4, 24'd10, 24'd999, 1'b0);
    push("luh_stall", 1);
    #1; check(32'(stall));
    push("luh_bubble_valid", 0); push("luh_bubble_we", 0); push("luh_next_stall", 0);
    step();
    check(32'(ex_valid)); check(32'(ex_we)); check(32'(stall));
    step();
    idle();
    mem_we = 1; mem_rd = 3'd2; mem_data = 24'h000777;
    push("luh_add_valid", 1); push("luh_ex_b_fwd", 24'h000777); push("luh_ex_a", 10);
    #1;
    check(32'(ex_valid)); check(32'(ex_b)); check(32'(ex_a));
    mem_we = 0;

    // Hold refresh: producer retires in the first hold cycle only.
    issue(3'd4, 3'd0, 3'd1, 24'h000010, 24'd0, 1'b0);
    step();
    issue(3'd6, 3'd6, 3'd7, 24'h000999, 24'h000999, 1'b0);
    ex_hold = 1;
    wb_we = 1; wb_rd = 3'd4; wb_data = 24'h000042;
    push("hold_stall", 1); push("hold_c1_ex_a", 24'h000042);
    #1; check(32'(stall)); check(32'(ex_a));
    step();
    wb_we = 0;
    push("hold_c2_ex_a", 24'h000042); push("hold_c2_ex_rs", 4);
    #1; check(32'(ex_a)); check(32'(ex_rs));
    step();
    push("hold_c3_ex_a", 24'h000042);
    #1; check(32'(ex_a));
    step();
    ex_hold = 0;
    push("hold_release_ex_a", 24'h000042); push("hold_release_stall", 0);
    #1; check(32'(ex_a)); check(32'(stall));
    idle();

    // Flush while a load-use hazard is present.
    issue(3'd0, 3'd0, 3'd2, 24'd0, 24'd0, 1'b1);
    step();
    issue(3'd2, 3'd2, 3'd3, 24'd1, 24'd1, 1'b0);
    push("flush_luh_pre_stall", 1);
    #1; check(32'(stall));
    flush = 1;
    push("flush_stall", 0);
    #1; check(32'(stall));
    push("flush_ex_valid", 0);
    step();
    check(32'(ex_valid));
    idle();

    // Asynchronous reset mid-stream, even with hold asserted.
    issue(3'd1, 3'd2, 3'd3, 24'h0000AA, 24'h0000BB, 1'b0);
    step();
    push("pre_reset_valid", 1);
    check(32'(ex_valid));
    rst_n = 0; ex_hold = 1; mem_we = 1; mem_rd = 3'd1; mem_data = 24'h00FFFF;
    push("async_reset_valid", 0); push("async_reset_stall", 0);
    push("async_reset_ex_a", 0); push("async_reset_ex_rd", 0);
    #1;
    check(32'(ex_valid)); check(32'(stall)); check(32'(ex_a)); check(32'(ex_rd));
    idle();
    rst_n = 1;
    issue(3'd1, 3'd2, 3'd6, 24'h000123, 24'h000456, 1'b0);
    push("post_reset_valid", 1); push("post_reset_rd", 6); push("post_reset_b", 24'h000456);
    step();
    idle();
    #1;
    check(32'(ex_valid)); check(32'(ex_rd)); check(32'(ex_b));

    if (expQ.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_leftover observed=%0d expected=0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
